// File: rtl/intr_msg_tx_if.sv
// Master-arbiter write handshake between intr_msg_tx and the PCI master core.
// Signal names are seen from the interrupt block: _o driven by it, _i driven by the core.
interface intr_msg_tx_if;
    logic        mst_req_o;
    logic [31:0] mst_addr_o;
    logic [31:0] mst_data_o;
    logic [3:0]  mst_be_o;
    logic        mst_ack_i;
    logic        mst_done_i;
    logic        mst_err_i;

    modport master (
        output mst_req_o, mst_addr_o, mst_data_o, mst_be_o,
        input  mst_ack_i, mst_done_i, mst_err_i
    );

    modport slave (
        input  mst_req_o, mst_addr_o, mst_data_o, mst_be_o,
        output mst_ack_i, mst_done_i, mst_err_i
    );
endinterface

// File: rtl/intr_msg_tx.sv
// Interrupt delivery to the PCI host: legacy INTA# level or one MSI write per event.
// Optional macro INTR_MSG_MULTI_EN adds multi-message vector substitution in the data low bits.
module intr_msg_tx #(
    parameter int unsigned RETRY_GAP = 16,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          intr_request,
    input  logic          intx_disable,
    input  logic          msi_enable,
    input  logic [31:0]   msi_addr,
    input  logic [15:0]   msi_data,
`ifdef INTR_MSG_MULTI_EN
    input  logic [4:0]    msi_vec_i,
    input  logic [2:0]    msi_mme,
`endif
    output logic          inta_n_o,
    output logic          intr_status_o,
    output logic          msi_drop_o,
    intr_msg_tx_if.master mst
);

    localparam int unsigned GAP_W = 8;
    localparam int unsigned RTY_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        BACKOFF,
        HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               req_q, req_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [3:0]         be_q, be_d;
    logic               inta_n_q, inta_n_d;
    logic               status_q, status_d;
    logic               drop_q, drop_d;
    logic [31:0]        msg_data_c;
    logic               unused_addr_lsb;

    assign unused_addr_lsb = ^msi_addr[1:0];

`ifdef INTR_MSG_MULTI_EN
    // Vector replaces the low data bits enabled by the multiple-message field (saturated at 5).
    logic [2:0] mme_sat_c;
    logic [4:0] vec_mask_c;

    assign mme_sat_c  = (msi_mme > 3'd5) ? 3'd5 : msi_mme;
    assign vec_mask_c = 5'((6'd1 << mme_sat_c) - 6'd1);
    assign msg_data_c = {16'h0, msi_data[15:5],
                         (msi_data[4:0] & ~vec_mask_c) | (msi_vec_i & vec_mask_c)};
`else
    assign msg_data_c = {16'h0, msi_data};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            retry_q  <= '0;
            gap_q    <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            be_q     <= '0;
            inta_n_q <= 1'b1;
            status_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            retry_q  <= retry_d;
            gap_q    <= gap_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            be_q     <= be_d;
            inta_n_q <= inta_n_d;
            status_q <= status_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        gap_d    = gap_q;
        addr_d   = addr_q;
        data_d   = data_q;
        be_d     = be_q;
        drop_d   = 1'b0;
        status_d = intr_request;
        inta_n_d = msi_enable | ~(intr_request & ~intx_disable);

        unique case (state_q)
            IDLE: begin
                if (msi_enable && intr_request) begin
                    state_d = ISSUE;
                    addr_d  = {msi_addr[31:2], 2'b00};
                    data_d  = msg_data_c;
                    be_d    = 4'b0011;
                    retry_d = '0;
                end
            end
            ISSUE: begin
                // An accepted request wins over a same-cycle disable.
                if (mst.mst_ack_i) begin
                    state_d = WAIT;
                end else if (!msi_enable) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (mst.mst_err_i) begin
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RTY_W'(1);
                        gap_d   = GAP_W'(RETRY_GAP);
                        state_d = BACKOFF;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = HOLD;
                    end
                end else if (mst.mst_done_i) begin
                    state_d = HOLD;
                end
            end
            BACKOFF: begin
                gap_d = gap_q - GAP_W'(1);
                if (gap_q <= GAP_W'(1)) begin
                    state_d = msi_enable ? ISSUE : IDLE;
                end
            end
            HOLD: begin
                if (!intr_request || !msi_enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_d = (state_d == ISSUE);
    end

    assign mst.mst_req_o  = req_q;
    assign mst.mst_addr_o = addr_q;
    assign mst.mst_data_o = data_q;
    assign mst.mst_be_o   = be_q;
    assign inta_n_o       = inta_n_q;
    assign intr_status_o  = status_q;
    assign msi_drop_o     = drop_q;

endmodule

// File: tb/tb_intr_msg_tx.sv
// Directed bench for intr_msg_tx: legacy vector table plus MSI, retry, abort and reset sequences.
module tb_intr_msg_tx;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        intr_request = 1'b0;
    logic        intx_disable = 1'b0;
    logic        msi_enable = 1'b0;
    logic [31:0] msi_addr = '0;
    logic [15:0] msi_data = '0;
`ifdef INTR_MSG_MULTI_EN
    logic [4:0]  msi_vec_i = '0;
    logic [2:0]  msi_mme = '0;
`endif
    logic        inta_n_o;
    logic        intr_status_o;
    logic        msi_drop_o;

    intr_msg_tx_if bus ();

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   req_starts = 0;
    int   drops = 0;
    logic req_prev = 1'b0;

    typedef struct {
        logic req;
        logic dis;
        logic exp_inta_n;
        logic exp_status;
    } vec_t;

    vec_t vecs [9];

    intr_msg_tx #(
        .RETRY_GAP (16),
        .MAX_RETRY (3)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .intr_request  (intr_request),
        .intx_disable  (intx_disable),
        .msi_enable    (msi_enable),
        .msi_addr      (msi_addr),
        .msi_data      (msi_data),
`ifdef INTR_MSG_MULTI_EN
        .msi_vec_i     (msi_vec_i),
        .msi_mme       (msi_mme),
`endif
        .inta_n_o      (inta_n_o),
        .intr_status_o (intr_status_o),
        .msi_drop_o    (msi_drop_o),
        .mst           (bus)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock, then sample 1 time unit after the edge and track request/drop activity.
    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        if (bus.mst_req_o && !req_prev) req_starts++;
        req_prev = bus.mst_req_o;
        if (msi_drop_o) drops++;
    endtask

    task automatic wait_req(input int max);
        int n = 0;
        while (bus.mst_req_o !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(bus.mst_req_o), 32'd1);
    endtask

    task automatic pulse_ack();
        bus.mst_ack_i = 1'b1; tick(); bus.mst_ack_i = 1'b0;
    endtask

    task automatic pulse_done();
        bus.mst_done_i = 1'b1; tick(); bus.mst_done_i = 1'b0;
    endtask

    initial begin
        int base;
        int t_err;

        bus.mst_ack_i  = 1'b0;
        bus.mst_done_i = 1'b0;
        bus.mst_err_i  = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0};

        // Reset values, with a live request held during reset.
        intr_request = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_inta_n", 32'(inta_n_o), 32'd1);
        chk("rst_status", 32'(intr_status_o), 32'd0);
        chk("rst_req", 32'(bus.mst_req_o), 32'd0);
        chk("rst_addr", bus.mst_addr_o, 32'h0);
        chk("rst_data", bus.mst_data_o, 32'h0);
        chk("rst_be", 32'(bus.mst_be_o), 32'h0);
        chk("rst_drop", 32'(msi_drop_o), 32'd0);
        intr_request = 1'b0;
        rst_i = 1'b0;
        tick();

        // Legacy mode vectors.
        for (int i = 0; i < 9; i++) begin
            intr_request = vecs[i].req;
            intx_disable = vecs[i].dis;
            tick();
            chk($sformatf("leg_inta_n[%0d]", i), 32'(inta_n_o), 32'(vecs[i].exp_inta_n));
            chk($sformatf("leg_status[%0d]", i), 32'(intr_status_o), 32'(vecs[i].exp_status));
            chk($sformatf("leg_req[%0d]", i), 32'(bus.mst_req_o), 32'd0);
        end

        // MSI basic write.
        intx_disable = 1'b0;
        intr_request = 1'b0;
        msi_enable   = 1'b1;
        msi_addr     = 32'hFEE0_1003;
        msi_data     = 16'h4021;
        tick();
        base = req_starts;
        intr_request = 1'b1;
        tick();
        chk("msi_req", 32'(bus.mst_req_o), 32'd1);
        chk("msi_addr", bus.mst_addr_o, 32'hFEE0_1000);
        chk("msi_data", bus.mst_data_o, 32'h0000_4021);
        chk("msi_be", 32'(bus.mst_be_o), 32'h3);
        chk("msi_inta_n", 32'(inta_n_o), 32'd1);
        chk("msi_status", 32'(intr_status_o), 32'd1);
        tick();
        tick();
        chk("msi_req_held", 32'(bus.mst_req_o), 32'd1);
        pulse_ack();
        chk("msi_req_after_ack", 32'(bus.mst_req_o), 32'd0);
        msi_addr = 32'h1234_5678;
        msi_data = 16'hBEEF;
        tick();
        chk("msi_addr_latched", bus.mst_addr_o, 32'hFEE0_1000);
        chk("msi_data_latched", bus.mst_data_o, 32'h0000_4021);
        pulse_done();
        repeat (100) tick();
        chk("msi_one_per_level", 32'(req_starts - base), 32'd1);
        msi_addr     = 32'hFEE0_1003;
        msi_data     = 16'h4021;
        intr_request = 1'b0;
        tick();
        intr_request = 1'b1;
        tick();
        chk("msi_second_req", 32'(req_starts - base), 32'd2);
        pulse_ack();
        pulse_done();

        // Retry: every attempt aborted.
        intr_request = 1'b0;
        tick();
        base = req_starts;
        intr_request = 1'b1;
        tick();
        t_err = 0;
        for (int a = 0; a < 4; a++) begin
            wait_req(40);
            if (a > 0) chk($sformatf("retry_gap[%0d]", a), 32'(cyc - t_err), 32'd16);
            chk($sformatf("retry_addr[%0d]", a), bus.mst_addr_o, 32'hFEE0_1000);
            pulse_ack();
            bus.mst_err_i = 1'b1;
            tick();
            bus.mst_err_i = 1'b0;
            t_err = cyc;
            chk($sformatf("retry_drop[%0d]", a), 32'(msi_drop_o), (a == 3) ? 32'd1 : 32'd0);
        end
        tick();
        chk("drop_one_cycle", 32'(msi_drop_o), 32'd0);
        repeat (40) tick();
        chk("retry_req_total", 32'(req_starts - base), 32'd4);
        chk("retry_drop_total", 32'(drops), 32'd1);
        chk("retry_hold_no_req", 32'(bus.mst_req_o), 32'd0);

        // Abort before ack.
        intr_request = 1'b0;
        tick();
        base = req_starts;
        intr_request = 1'b1;
        tick();
        chk("abort_req", 32'(bus.mst_req_o), 32'd1);
        msi_enable = 1'b0;
        tick();
        chk("abort_req_drop", 32'(bus.mst_req_o), 32'd0);
        chk("abort_inta_n", 32'(inta_n_o), 32'd0);
        repeat (5) tick();
        chk("abort_no_write", 32'(req_starts - base), 32'd1);

        // Disable after ack: the write runs to completion, no new request.
        msi_enable = 1'b1;
        tick();
        chk("ack_path_req", 32'(bus.mst_req_o), 32'd1);
        chk("ack_path_inta_n", 32'(inta_n_o), 32'd1);
        pulse_ack();
        msi_enable = 1'b0;
        tick();
        tick();
        chk("wait_legacy_inta_n", 32'(inta_n_o), 32'd0);
        msi_enable = 1'b1;
        tick();
        tick();
        chk("wait_no_new_req", 32'(bus.mst_req_o), 32'd0);
        pulse_done();
        repeat (5) tick();
        chk("wait_req_total", 32'(req_starts - base), 32'd2);

        // Reset during WAIT.
        intr_request = 1'b0;
        tick();
        intr_request = 1'b1;
        tick();
        chk("pre_rst_req", 32'(bus.mst_req_o), 32'd1);
        pulse_ack();
        #2;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_req", 32'(bus.mst_req_o), 32'd0);
        chk("mid_rst_inta_n", 32'(inta_n_o), 32'd1);
        chk("mid_rst_addr", bus.mst_addr_o, 32'h0);
        chk("mid_rst_be", 32'(bus.mst_be_o), 32'h0);
        rst_i = 1'b0;
        tick();
        chk("post_rst_req", 32'(bus.mst_req_o), 32'd1);
        chk("post_rst_addr", bus.mst_addr_o, 32'hFEE0_1000);
        pulse_ack();
        pulse_done();

`ifdef INTR_MSG_MULTI_EN
        // Multi-message vector substitution.
        intr_request = 1'b0;
        msi_data     = 16'h4020;
        msi_mme      = 3'd3;
        msi_vec_i    = 5'd5;
        tick();
        intr_request = 1'b1;
        tick();
        chk("multi_mme3", bus.mst_data_o, 32'h0000_4025);
        pulse_ack();
        pulse_done();
        intr_request = 1'b0;
        msi_mme      = 3'd0;
        tick();
        intr_request = 1'b1;
        tick();
        chk("multi_mme0", bus.mst_data_o, 32'h0000_4020);
        pulse_ack();
        pulse_done();
        intr_request = 1'b0;
        msi_mme      = 3'd7;
        msi_vec_i    = 5'h1A;
        tick();
        intr_request = 1'b1;
        tick();
        chk("multi_mme7", bus.mst_data_o, 32'h0000_403A);
        pulse_ack();
        pulse_done();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/intr_msg_tx.md
Name: intr_msg_tx

Overview:
- Delivers the level `intr_request` from the e1000 interrupt controller to the PCI host.
- Two delivery modes, selected by config-space bits:
  - legacy INTA# (level, open-drain style, active-low);
  - MSI, as a single 32-bit memory write per interrupt event, issued through the PCI master arbiter request/ack/done handshake.
- Sits between the interrupt controller and the PCI target/master core.

Parameters:
- RETRY_GAP, 16: idle cycles inserted after `mst_err` before re-issuing an MSI write (1..255).
- MAX_RETRY, 3: number of re-issues after the first failed attempt before the event is dropped (0..15).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-high
- intr_request  in  1  level interrupt from the interrupt controller
- intx_disable  in  1  PCI command register bit 10
- msi_enable  in  1  MSI control register enable bit
- msi_addr  in  32  MSI message address; bits [1:0] ignored
- msi_data  in  16  MSI message data
- inta_n_o  out  1  legacy interrupt pin, active-low
- intr_status_o  out  1  PCI status register bit 3 (interrupt status)
- mst_req_o  out  1  master write request
- mst_addr_o  out  32  write address
- mst_data_o  out  32  write data
- mst_be_o  out  4  byte enables
- mst_ack_i  in  1  master accepted the request (1-cycle pulse)
- mst_done_i  in  1  write completed OK (1-cycle pulse)
- mst_err_i  in  1  write aborted (master/target abort; 1-cycle pulse)
- msi_drop_o  out  1  1-cycle pulse when an event is dropped after retries are exhausted

Behaviour:
- Reset values:
  - `inta_n_o` = 1; `intr_status_o` = 0; `mst_req_o` = 0.
  - `mst_addr_o`, `mst_data_o`, `mst_be_o` = 0.
  - `msi_drop_o` = 0; state = IDLE; retry and gap counters = 0.
- Status output:
  - `intr_status_o` is `intr_request` registered (1-cycle latency).
  - It is independent of the mode and of `intx_disable`.
- Legacy mode (`msi_enable` = 0):
  - `inta_n_o` is registered `~(intr_request & ~intx_disable)`; 1-cycle latency.
  - The MSI FSM stays in IDLE.
- MSI mode (`msi_enable` = 1):
  - `inta_n_o` is forced to 1 on the next cycle.
- FSM states:
  - IDLE: if `msi_enable & intr_request`, latch the message and go to ISSUE. Latched values:
    - `mst_addr_o` = {`msi_addr`[31:2], 2'b00}
    - `mst_data_o` = {16'h0, `msi_data`}
    - `mst_be_o` = 4'b0011
    - retry counter cleared.
  - ISSUE: `mst_req_o` = 1 and held until the cycle `mst_ack_i` = 1. Next cycle: `mst_req_o` = 0, go to WAIT.
    - If `msi_enable` drops while still in ISSUE without ack: `mst_req_o` drops, go to IDLE, no write.
  - WAIT: wait for `mst_done_i` or `mst_err_i`. Ignores `msi_enable` changes: a started transaction always completes.
    - `mst_done_i` goes to HOLD.
    - `mst_err_i` with retry counter < MAX_RETRY: increment retry counter, load gap counter with RETRY_GAP, go to BACKOFF.
    - `mst_err_i` with retry counter = MAX_RETRY: pulse `msi_drop_o`, go to HOLD.
    - `mst_done_i` and `mst_err_i` in the same cycle: treat as `mst_err_i`.
  - BACKOFF: decrement the gap counter each cycle. At 0, go to ISSUE, re-sending the latched message.
    - If `msi_enable` = 0 at that point, go to IDLE instead.
  - HOLD: one message per assertion (edge semantics). Stay while `intr_request` = 1; go to IDLE when `intr_request` = 0 or `msi_enable` = 0.
    - A new event needs at least one cycle with `intr_request` low.
- Message contents:
  - Address and data are latched at IDLE→ISSUE.
  - Config changes during the transaction do not affect it.
- Mode switches:
  - Switching MSI→legacy while `intr_request` = 1 asserts `inta_n_o` one cycle after `msi_enable` falls (if `intx_disable` = 0).
  - Switching legacy→MSI while `intr_request` = 1 starts an MSI write from IDLE.
- Reset mid-transaction: all outputs return to reset values immediately. The master core is responsible for abandoning any acked transfer.
- `mst_ack_i` / `mst_done_i` / `mst_err_i` outside ISSUE/WAIT are ignored.

Optional Feature:
- Macro: INTR_MSG_MULTI_EN.
- Defined:
  - Adds input `msi_vec_i` [4:0] (event vector) and input `msi_mme` [2:0] (multiple-message-enable).
  - Data low bits are replaced: `mst_data_o`[4:0] = (`msi_data`[4:0] & ~mask) | (`msi_vec_i` & mask), where mask = (1<<`msi_mme`) - 1 and `msi_mme` > 5 is treated as 5.
  - Vector latched at IDLE→ISSUE.
- Undefined: the ports do not exist; data is `msi_data` unchanged.

Test Plan:
- Legacy mode:
  - `intr_request` 0→1 at cycle 10 → `inta_n_o` = 0 at cycle 11 and `intr_status_o` = 1.
  - Set `intx_disable` = 1 → `inta_n_o` = 1 next cycle while `intr_status_o` stays 1.
- MSI basic:
  - Setup: `msi_enable` = 1, `msi_addr` = 32'hFEE0_1003, `msi_data` = 16'h4021; `intr_request` rises; ack after 3 cycles; done 2 cycles later.
  - Expect exactly one request with addr 32'hFEE0_1000, data 32'h0000_4021, be 4'b0011.
  - Holding `intr_request` high 100 cycles produces no second request. Dropping it for 1 cycle and raising it again produces a second write.
- Retry: every attempt gets `mst_err_i` with MAX_RETRY = 3, RETRY_GAP = 16 → 4 requests total, each spaced 16 idle cycles after the error; `msi_drop_o` pulses once; FSM in HOLD.
- Abort:
  - Clear `msi_enable` while `mst_req_o` = 1 before ack → `mst_req_o` = 0 next cycle, no write. If `intr_request` = 1 and `intx_disable` = 0, `inta_n_o` = 0.
  - Clear `msi_enable` after ack → FSM waits for done; no new request.
- Reset: assert `rst_i` in WAIT → `mst_req_o` = 0, `inta_n_o` = 1, state IDLE immediately. After release with `intr_request` = 1 and `msi_enable` = 1 → a new request 1 cycle later.
- INTR_MSG_MULTI_EN:
  - `msi_data` = 16'h4020, `msi_mme` = 3, `msi_vec_i` = 5'd5 → `mst_data_o` = 32'h0000_4025.
  - `msi_mme` = 0 → 32'h0000_4020.
